// File: rtl/mfp_input_conditioner.sv
// mfp_input_conditioner: per-channel synchroniser, debouncer, rise/fall pulse generator and sticky flags.
// Optional interrupt output (irq_mask/irq ports) is built only when MFP_INCOND_IRQ_EN is defined.
module mfp_input_conditioner #(
  parameter int N_CH        = 21,
  parameter int DB_CYCLES   = 500000,
  parameter int SYNC_STAGES = 2,
  parameter int RST_LEVEL   = 0
) (
  input  logic            SI_ClkIn,
  input  logic            SI_Reset_N,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] db_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] sticky,
  input  logic [N_CH-1:0] clr_mask
`ifdef MFP_INCOND_IRQ_EN
  ,
  input  logic [N_CH-1:0] irq_mask,
  output logic            irq
`endif
);

  localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [N_CH-1:0]  RST_VEC  = (RST_LEVEL != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

  logic [N_CH-1:0]  sync_r [SYNC_STAGES];
  logic [N_CH-1:0]  sync_s;
  logic [CNT_W-1:0] cnt_r [N_CH];
  logic [CNT_W-1:0] cnt_next_s [N_CH];
  logic [N_CH-1:0]  db_r;
  logic [N_CH-1:0]  db_next_s;
  logic [N_CH-1:0]  rise_r;
  logic [N_CH-1:0]  fall_r;
  logic [N_CH-1:0]  sticky_r;
  logic [N_CH-1:0]  sticky_next_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Metastability chain: raw pins enter stage 0 and emerge from the last stage.
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= RST_VEC;
      end
    end else begin
      sync_r[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Debounce decision: any agreement restarts the count, DB_CYCLES disagreeing cycles commit the new level.
  always_comb begin
    for (int ch = 0; ch < N_CH; ch++) begin
      cnt_next_s[ch] = cnt_r[ch];
      db_next_s[ch]  = db_r[ch];
      if (sync_s[ch] == db_r[ch]) begin
        cnt_next_s[ch] = {CNT_W{1'b0}};
      end else if (cnt_r[ch] == CNT_LAST) begin
        cnt_next_s[ch] = {CNT_W{1'b0}};
        db_next_s[ch]  = sync_s[ch];
      end else begin
        cnt_next_s[ch] = cnt_r[ch] + CNT_W'(1);
      end
    end
  end

  // A rise still showing on rise_r beats a coincident clear, so no event is lost.
  always_comb begin
    sticky_next_s = (sticky_r & ~clr_mask) | rise_r;
  end

  // Debounced level, edge pulses and sticky flags all update on the same edge.
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        cnt_r[ch] <= {CNT_W{1'b0}};
      end
      db_r     <= RST_VEC;
      rise_r   <= {N_CH{1'b0}};
      fall_r   <= {N_CH{1'b0}};
      sticky_r <= {N_CH{1'b0}};
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        cnt_r[ch] <= cnt_next_s[ch];
      end
      db_r     <= db_next_s;
      rise_r   <= db_next_s & ~db_r;
      fall_r   <= ~db_next_s & db_r;
      sticky_r <= sticky_next_s;
    end
  end

  assign db_out     = db_r;
  assign rise_pulse = rise_r;
  assign fall_pulse = fall_r;
  assign sticky     = sticky_r;

`ifdef MFP_INCOND_IRQ_EN
  logic irq_r;

  // Interrupt follows the sticky flags being loaded this cycle, gated by the enable mask.
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |(sticky_next_s & irq_mask);
    end
  end

  assign irq = irq_r;
`endif

endmodule

// File: tb/tb_mfp_input_conditioner.sv
// Self-checking bench for mfp_input_conditioner (N_CH=4, DB_CYCLES=4, SYNC_STAGES=2, RST_LEVEL=0).
// Directed scenarios plus randomized traffic against a sliding-window reference model.
module tb_mfp_input_conditioner;

  localparam int N  = 4;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] raw_in = 4'h0;
  logic [N-1:0] clr_mask = 4'h0;
  logic [N-1:0] irq_mask = 4'h0;
  logic [N-1:0] db_out, rise_pulse, fall_pulse, sticky;
  logic         irq;

  int n_checks = 0;
  int n_pass = 0;

  // reference model state
  logic [N-1:0] m_pipe [2];
  logic [N-1:0] m_win [DB];
  logic [N-1:0] m_db, m_rise, m_fall, m_sticky;
  logic         m_irq;

  mfp_input_conditioner #(
    .N_CH(N), .DB_CYCLES(DB), .SYNC_STAGES(2), .RST_LEVEL(0)
  ) dut (
    .SI_ClkIn(clk),
    .SI_Reset_N(rst_n),
    .raw_in(raw_in),
    .db_out(db_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .sticky(sticky),
    .clr_mask(clr_mask)
`ifdef MFP_INCOND_IRQ_EN
    ,
    .irq_mask(irq_mask),
    .irq(irq)
`endif
  );

`ifndef MFP_INCOND_IRQ_EN
  assign irq = 1'b0;
`endif

  always #5 clk = ~clk;

  // Model: a channel flips when the last DB synchronised samples all disagree with its level.
  task automatic model_edge();
    logic [N-1:0] s, new_db, stk;
    if (!rst_n) begin
      m_pipe[0] = '0; m_pipe[1] = '0;
      for (int k = 0; k < DB; k++) m_win[k] = '0;
      m_db = '0; m_rise = '0; m_fall = '0; m_sticky = '0; m_irq = 1'b0;
    end else begin
      s = m_pipe[1];
      for (int k = 0; k < DB - 1; k++) m_win[k] = m_win[k+1];
      m_win[DB-1] = s;
      new_db = m_db;
      for (int ch = 0; ch < N; ch++) begin
        int diff = 0;
        for (int k = 0; k < DB; k++) if (m_win[k][ch] != m_db[ch]) diff++;
        if (diff == DB) new_db[ch] = ~m_db[ch];
      end
      stk = (m_sticky & ~clr_mask) | m_rise;
      m_irq = |(stk & irq_mask);
      m_rise = new_db & ~m_db;
      m_fall = ~new_db & m_db;
      m_db = new_db;
      m_sticky = stk;
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = raw_in;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw_in = 4'hF;
    #1;
    n_checks++;
    if (db_out !== 4'h0 || rise_pulse !== 4'h0 || fall_pulse !== 4'h0 || sticky !== 4'h0)
      $display("FAIL reset_async: got db=%h r=%h f=%h st=%h, want all 0", db_out, rise_pulse, fall_pulse, sticky);
    else n_pass++;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (db_out !== 4'h0 || rise_pulse !== 4'h0 || sticky !== 4'h0 || irq !== 1'b0)
      $display("FAIL reset_held: got db=%h r=%h st=%h irq=%b, want 0", db_out, rise_pulse, sticky, irq);
    else n_pass++;
    raw_in = 4'h0;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (rise_pulse !== 4'h0 || fall_pulse !== 4'h0 || db_out !== 4'h0)
      $display("FAIL reset_release: got r=%h f=%h db=%h, want 0", rise_pulse, fall_pulse, db_out);
    else n_pass++;
  endtask

  task automatic test_rise();
    raw_in = 4'h1;
    for (int c = 1; c <= 6; c++) begin
      step();
      n_checks++;
      if (c < 6 && (db_out[0] !== 1'b0 || rise_pulse[0] !== 1'b0))
        $display("FAIL rise_early c=%0d: got db=%b r=%b, want 0", c, db_out[0], rise_pulse[0]);
      else if (c == 6 && (db_out[0] !== 1'b1 || rise_pulse[0] !== 1'b1))
        $display("FAIL rise_edge: got db=%b r=%b, want 1 1", db_out[0], rise_pulse[0]);
      else n_pass++;
    end
    step();
    n_checks++;
    if (rise_pulse[0] !== 1'b0 || sticky[0] !== 1'b1 || db_out[0] !== 1'b1)
      $display("FAIL rise_after: got r=%b st=%b db=%b, want 0 1 1", rise_pulse[0], sticky[0], db_out[0]);
    else n_pass++;
  endtask

  task automatic test_glitch();
    raw_in[1] = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c == 3) raw_in[1] = 1'b0;
      step();
      n_checks++;
      if (db_out[1] !== 1'b0 || rise_pulse[1] !== 1'b0 || sticky[1] !== 1'b0)
        $display("FAIL glitch c=%0d: got db=%b r=%b st=%b, want 0", c, db_out[1], rise_pulse[1], sticky[1]);
      else n_pass++;
    end
  endtask

  task automatic test_clear();
    clr_mask = 4'h1;
    step();
    clr_mask = 4'h0;
    n_checks++;
    if (sticky[0] !== 1'b0) $display("FAIL clear_ch0: got %b want 0", sticky[0]);
    else n_pass++;
    raw_in[2] = 1'b1;
    for (int c = 0; c < 6; c++) step();
    n_checks++;
    if (rise_pulse[2] !== 1'b1) $display("FAIL clear_rise2: got %b want 1", rise_pulse[2]);
    else n_pass++;
    clr_mask = 4'h4;
    step();
    clr_mask = 4'h0;
    n_checks++;
    if (sticky[2] !== 1'b1 || sticky[0] !== 1'b0)
      $display("FAIL clear_set_wins: got st=%h want bit2=1 bit0=0", sticky);
    else n_pass++;
  endtask

  task automatic test_fall();
    logic st3;
    raw_in[3] = 1'b1;
    for (int c = 0; c < 8; c++) step();
    n_checks++;
    if (db_out[3] !== 1'b1) $display("FAIL fall_setup: got db3=%b want 1", db_out[3]);
    else n_pass++;
    st3 = m_sticky[3];
    raw_in[3] = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      n_checks++;
      if (fall_pulse[3] !== (c == 6) || db_out[3] !== (c != 6))
        $display("FAIL fall c=%0d: got f=%b db=%b", c, fall_pulse[3], db_out[3]);
      else n_pass++;
    end
    step();
    n_checks++;
    if (fall_pulse[3] !== 1'b0 || sticky[3] !== st3 || st3 !== 1'b1)
      $display("FAIL fall_after: got f=%b st=%b want 0 1", fall_pulse[3], sticky[3]);
    else n_pass++;
  endtask

`ifdef MFP_INCOND_IRQ_EN
  task automatic test_irq();
    clr_mask = 4'hF;
    step();
    clr_mask = 4'h0;
    irq_mask = 4'h2;
    raw_in[1] = 1'b1;
    for (int c = 0; c < 6; c++) step();
    n_checks++;
    if (irq !== 1'b0 || rise_pulse[1] !== 1'b1) $display("FAIL irq_pre: got irq=%b r1=%b want 0 1", irq, rise_pulse[1]);
    else n_pass++;
    step();
    n_checks++;
    if (irq !== 1'b1 || sticky[1] !== 1'b1) $display("FAIL irq_set: got irq=%b st1=%b want 1 1", irq, sticky[1]);
    else n_pass++;
    clr_mask = 4'h2;
    step();
    clr_mask = 4'h0;
    n_checks++;
    if (irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq);
    else n_pass++;
    raw_in[0] = 1'b0;
    for (int c = 0; c < 8; c++) step();
    raw_in[0] = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      n_checks++;
      if (irq !== 1'b0) $display("FAIL irq_masked c=%0d: got %b want 0", c, irq);
      else n_pass++;
    end
    n_checks++;
    if (sticky[0] !== 1'b1) $display("FAIL irq_masked_sticky: got %b want 1", sticky[0]);
    else n_pass++;
  endtask
`endif

  task automatic test_mid_reset();
    raw_in = 4'hF;
    for (int c = 0; c < 8; c++) step();
    n_checks++;
    if (db_out !== 4'hF) $display("FAIL midrst_setup: got %h want f", db_out);
    else n_pass++;
    raw_in = 4'h0;
    for (int c = 0; c < 4; c++) step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (db_out !== 4'h0 || sticky !== 4'h0) $display("FAIL midrst_async: got db=%h st=%h want 0", db_out, sticky);
    else n_pass++;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      n_checks++;
      if (db_out !== 4'h0 || rise_pulse !== 4'h0 || fall_pulse !== 4'h0)
        $display("FAIL midrst_after c=%0d: got db=%h r=%h f=%h want 0", c, db_out, rise_pulse, fall_pulse);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int ch = 0; ch < N; ch++) if ($urandom_range(0, 6) == 0) raw_in[ch] = ~raw_in[ch];
      clr_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if ($urandom_range(0, 49) == 0) irq_mask = 4'($urandom_range(0, 15));
      step();
      n_checks++;
      if (db_out !== m_db || rise_pulse !== m_rise || fall_pulse !== m_fall || sticky !== m_sticky)
        $display("FAIL random c=%0d: got db=%h r=%h f=%h st=%h want db=%h r=%h f=%h st=%h",
                 c, db_out, rise_pulse, fall_pulse, sticky, m_db, m_rise, m_fall, m_sticky);
      else n_pass++;
`ifdef MFP_INCOND_IRQ_EN
      n_checks++;
      if (irq !== m_irq) $display("FAIL random_irq c=%0d: got %b want %b", c, irq, m_irq);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_rise();
    test_glitch();
    test_clear();
    test_fall();
`ifdef MFP_INCOND_IRQ_EN
    test_irq();
`endif
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
